// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: store-size codes,
// sequencer state encoding and the per-access size/alignment helpers.
package dmem_pkg;

    localparam logic [2:0] WT_BYTE = 3'd0;
    localparam logic [2:0] WT_HALF = 3'd1;
    localparam logic [2:0] WT_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bytes touched by an access; loads are always a full word.
    function automatic logic [2:0] access_size(input logic write, input logic [2:0] wtype);
        if (!write) begin
            return 3'd4;
        end
        case (wtype)
            WT_BYTE: return 3'd1;
            WT_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Natural alignment for the access size.
    function automatic logic access_aligned(input logic write, input logic [2:0] wtype,
                                            input logic [1:0] addr_lo);
        if (!write) begin
            return addr_lo == 2'b00;
        end
        case (wtype)
            WT_BYTE: return 1'b1;
            WT_HALF: return !addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. A lone requester always wins; on a tie the
// requester named by rr_ptr wins.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant,
    output logic gnt_id
);

    // Pick the winner for this cycle.
    always_comb begin
        grant  = valid0 | valid1;
        gnt_id = (valid0 && valid1) ? rr_ptr : valid1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-ported data
// memory. Each granted access is checked, issued once, watched by a
// watchdog and completed with a one-cycle done/err pulse to its owner.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [2:0]  req0_wtype,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [2:0]  req1_wtype,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_wtype,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state_reg, state_next;
    logic            owner_reg, rr_ptr_reg, err_reg;
    logic [WD_W-1:0] wd_cnt_reg;
    logic            write_reg;
    logic [31:0]     addr_reg, wdata_reg, rdata0_reg, rdata1_reg;
    logic [2:0]      wtype_reg;

    logic            grant, gnt_id, take, check_ok, ack_seen, timed_out;
    logic            sel_write;
    logic [31:0]     sel_addr, sel_wdata;
    logic [2:0]      sel_wtype;
    logic [32:0]     end_addr;

    rr_arbiter2 u_rr (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr_reg),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    // Steer the winning requester's fields and check them; range sum is
    // done one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        sel_write = gnt_id ? req1_write : req0_write;
        sel_addr  = gnt_id ? req1_addr  : req0_addr;
        sel_wdata = gnt_id ? req1_wdata : req0_wdata;
        sel_wtype = gnt_id ? req1_wtype : req0_wtype;
        end_addr  = {1'b0, sel_addr} + {30'd0, access_size(sel_write, sel_wtype)};
        check_ok  = access_aligned(sel_write, sel_wtype, sel_addr[1:0])
                    && (end_addr <= 33'(ADDR_LIMIT))
                    && (!sel_write || (sel_wtype <= WT_WORD));
        take      = (state_reg == IDLE) && grant;
        ack_seen  = (state_reg == WAIT) && mem_ack;
        timed_out = (state_reg == WAIT) && !mem_ack && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
    end

    // Next state and pulse outputs; ready is gated by reset so nothing is
    // offered while the sequencer is held in reset.
    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        req0_err   = 1'b0;
        req1_err   = 1'b0;
        mem_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (take) begin
                    req0_ready = reset_n && !gnt_id;
                    req1_ready = reset_n && gnt_id;
                    state_next = check_ok ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                mem_req    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (ack_seen || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                req0_done  = !owner_reg;
                req1_done  = owner_reg;
                req0_err   = !owner_reg && err_reg;
                req1_err   = owner_reg && err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the granted access, its error status and returned load data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg  <= 1'b0;
            err_reg    <= 1'b0;
            write_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wtype_reg  <= '0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            if (take) begin
                owner_reg <= gnt_id;
                err_reg   <= !check_ok;
                write_reg <= sel_write;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                wtype_reg <= sel_wtype;
            end
            if (ack_seen && !write_reg) begin
                if (owner_reg) begin
                    rdata1_reg <= mem_rdata;
                end else begin
                    rdata0_reg <= mem_rdata;
                end
            end
            if (timed_out) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Watchdog counts WAIT cycles; fairness pointer flips away from the
    // requester just served.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg <= '0;
            rr_ptr_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE) begin
                wd_cnt_reg <= '0;
            end else if ((state_reg == WAIT) && !mem_ack) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end
            if (state_reg == RESP) begin
                rr_ptr_reg <= ~owner_reg;
            end
        end
    end

    assign mem_write  = write_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign mem_wtype  = wtype_reg;
    assign req0_rdata = rdata0_reg;
    assign req1_rdata = rdata1_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus tasks push the expected
// completion per requester, a monitor pops and compares on every done.
module tb_dmem_arbiter;

    localparam logic [2:0] WB = 3'd0;
    localparam logic [2:0] WH = 3'd1;
    localparam logic [2:0] WW = 3'd2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  valid, write, ready, done, err;
    logic [31:0] addr_a  [2];
    logic [31:0] wdata_a [2];
    logic [2:0]  wtype_a [2];
    logic [31:0] rdata0, rdata1;
    logic        mem_req, mem_write, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [2:0]  mem_wtype;
    logic        ack_model = 1'b0;
    logic        ack_inject = 1'b0;

    int cyc = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    int mem_req_cnt = 0;
    int checks = 0;
    int fails = 0;
    int last_ready [2];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(valid[0]), .req0_write(write[0]), .req0_addr(addr_a[0]),
        .req0_wdata(wdata_a[0]), .req0_wtype(wtype_a[0]), .req0_ready(ready[0]),
        .req0_done(done[0]), .req0_rdata(rdata0), .req0_err(err[0]),
        .req1_valid(valid[1]), .req1_write(write[1]), .req1_addr(addr_a[1]),
        .req1_wdata(wdata_a[1]), .req1_wtype(wtype_a[1]), .req1_ready(ready[1]),
        .req1_done(done[1]), .req1_rdata(rdata1), .req1_err(err[1]),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wtype(mem_wtype), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    assign mem_ack = ack_model | ack_inject;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: acks ack_delay cycles after mem_req (0 = never);
    // returned data is a fixed pattern of the address.
    always @(negedge clock) begin
        if (!reset_n) begin
            ack_cnt   <= 0;
            ack_model <= 1'b0;
        end else begin
            ack_model <= (ack_cnt == 1);
            if (ack_cnt == 1) mem_rdata <= 32'hA5A5_0000 ^ mem_addr;
            if (mem_req) ack_cnt <= ack_delay;
            else if (ack_cnt > 0) ack_cnt <= ack_cnt - 1;
            if (mem_req) mem_req_cnt <= mem_req_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_done(input int id);
        exp_t e;
        logic [31:0] rd;
        rd = (id == 0) ? rdata0 : rdata1;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done id=%0d actual=1 required=0", id);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else e = q1.pop_front();
        $display("txn id=%0d err=%0b rdata=%08h lat=%0d", id, err[id], rd, cyc - last_ready[id]);
        check($sformatf("err%0d", id), 64'(err[id]), 64'(e.err));
        check($sformatf("rdata%0d", id), 64'(rd), 64'(e.rdata));
        check($sformatf("latency%0d", id), 64'(cyc - last_ready[id]), 64'(e.lat));
    endtask

    // Monitor: every done pulse is matched against its requester's queue.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (done[i]) check_done(i);
                end
            end
        end
    end

    task automatic issue(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input logic e_err, input logic [31:0] e_rd,
                         input int e_lat, input logic push, output int rc);
        exp_t e;
        e.err = e_err;
        e.rdata = e_rd;
        e.lat = e_lat;
        if (push) begin
            if (id == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clock);
        write[id] = w;
        addr_a[id] = a;
        wdata_a[id] = d;
        wtype_a[id] = t;
        valid[id] = 1'b1;
        rc = -1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (ready[id]) begin
                rc = cyc;
                break;
            end
            @(negedge clock);
        end
        if (rc < 0) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout id=%0d actual=0 required=1", id);
            valid[id] = 1'b0;
            return;
        end
        last_ready[id] = rc;
        @(posedge clock);
        #1;
        valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (q0.size() + q1.size()) != 0; n++) @(negedge clock);
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({ready, done, err, mem_req, mem_write, mem_wtype}), 64'd0);
        check({tag, "_rdata"}, {rdata0, rdata1}, 64'd0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rc_a, rc_b, rc_c, rc, mq;
        reset_n = 1'b0;
        valid = '0;
        write = '0;
        for (int i = 0; i < 2; i++) begin
            addr_a[i] = '0;
            wdata_a[i] = '0;
            wtype_a[i] = '0;
            last_ready[i] = 0;
        end
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Tie from reset: req0 first; req0 re-requests while req1 waits, so
        // the second tie goes to req1.
        ack_delay = 1;
        fork
            begin
                issue(0, 1'b0, 32'h20, 32'h0, WW, 1'b0, 32'hA5A5_0020, 3, 1'b1, rc_a);
                issue(0, 1'b1, 32'h28, 32'h1234, WW, 1'b0, 32'hA5A5_0020, 3, 1'b1, rc_c);
            end
            issue(1, 1'b0, 32'h24, 32'h0, WW, 1'b0, 32'hA5A5_0024, 3, 1'b1, rc_b);
        join
        check("tie_req1_after_req0", 64'(rc_b - rc_a), 64'd4);
        check("tie2_req0_after_req1", 64'(rc_c - rc_a), 64'd8);
        drain();

        // Load with ack two cycles after mem_req.
        ack_delay = 2;
        issue(0, 1'b0, 32'h10, 32'h0, WW, 1'b0, 32'hA5A5_0010, 4, 1'b1, rc);
        drain();
        check("mem_addr_held", 64'(mem_addr), 64'h10);
        check("mem_write_held", 64'(mem_write), 64'd0);

        // Error fast path: never touches memory.
        ack_delay = 1;
        mq = mem_req_cnt;
        issue(0, 1'b1, 32'h02, 32'h1, WW, 1'b1, 32'hA5A5_0010, 1, 1'b1, rc);
        issue(0, 1'b1, 32'h03, 32'h1, WH, 1'b1, 32'hA5A5_0010, 1, 1'b1, rc);
        issue(0, 1'b1, 32'h00, 32'h1, 3'd5, 1'b1, 32'hA5A5_0010, 1, 1'b1, rc);
        issue(0, 1'b0, 32'h02, 32'h0, WW, 1'b1, 32'hA5A5_0010, 1, 1'b1, rc);
        drain();
        check("err_no_mem_req", 64'(mem_req_cnt - mq), 64'd0);

        // Range boundary at ADDR_LIMIT.
        mq = mem_req_cnt;
        issue(1, 1'b1, 32'h3FC, 32'hDEADBEEF, WW, 1'b0, 32'hA5A5_0024, 3, 1'b1, rc);
        issue(1, 1'b1, 32'h3FF, 32'h55, WB, 1'b0, 32'hA5A5_0024, 3, 1'b1, rc);
        issue(1, 1'b1, 32'h3FE, 32'h6677, WH, 1'b0, 32'hA5A5_0024, 3, 1'b1, rc);
        issue(1, 1'b1, 32'h3FE, 32'h1, WW, 1'b1, 32'hA5A5_0024, 1, 1'b1, rc);
        issue(1, 1'b1, 32'h400, 32'h1, WW, 1'b1, 32'hA5A5_0024, 1, 1'b1, rc);
        issue(1, 1'b1, 32'hFFFF_FFFC, 32'h1, WW, 1'b1, 32'hA5A5_0024, 1, 1'b1, rc);
        drain();
        check("range_mem_req_count", 64'(mem_req_cnt - mq), 64'd3);

        // Watchdog: no ack -> err after 16 WAIT cycles; ack on last WAIT cycle wins.
        ack_delay = 0;
        issue(1, 1'b0, 32'h40, 32'h0, WW, 1'b1, 32'hA5A5_0024, 18, 1'b1, rc);
        drain();
        ack_delay = 16;
        issue(0, 1'b0, 32'h44, 32'h0, WW, 1'b0, 32'hA5A5_0044, 18, 1'b1, rc);
        drain();

        // Stale ack in IDLE is ignored.
        ack_delay = 1;
        mq = mem_req_cnt;
        @(negedge clock);
        ack_inject = 1'b1;
        @(negedge clock);
        ack_inject = 1'b0;
        repeat (3) @(negedge clock);
        check("stale_ack_no_mem_req", 64'(mem_req_cnt - mq), 64'd0);
        issue(0, 1'b0, 32'h48, 32'h0, WW, 1'b0, 32'hA5A5_0048, 3, 1'b1, rc);
        drain();

        // Reset while in WAIT: outputs clear at once, no done afterwards.
        ack_delay = 0;
        mq = mem_req_cnt;
        issue(0, 1'b0, 32'h50, 32'h0, WW, 1'b0, 32'h0, 0, 1'b0, rc);
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (25) @(negedge clock);
        check("reset_one_issue", 64'(mem_req_cnt - mq), 64'd1);
        ack_delay = 1;
        issue(1, 1'b0, 32'h54, 32'h0, WW, 1'b0, 32'hA5A5_0054, 3, 1'b1, rc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
